// File: rtl/master_control.sv
// Master side of the Chip2Chip request/ack/valid handshake: latches a switch
// value on a send pulse, requests the slave, shows a notice, then strobes valid.
module master_control #(
  parameter int CNT_MAX = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] data_sw,
  input  logic       ack,
  output logic       request,
  output logic       valid,
  output logic [2:0] data_out,
  output logic       notice,
  output logic       busy
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    NOTICE = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          ack_m, ack_s;
  logic [CW-1:0] cnt, cnt_n;
  logic          cnt_done;
  logic          request_n, valid_n, notice_n;
  logic [2:0]    data_n;

  // ack comes from the other board; only ack_s may steer the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  // state register, with the link outputs registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      request  <= 1'b0;
      valid    <= 1'b0;
      notice   <= 1'b0;
      data_out <= 3'b000;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      request  <= request_n;
      valid    <= valid_n;
      notice   <= notice_n;
      data_out <= data_n;
    end
  end

  assign cnt_done = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (send)     state_n = REQ;
      REQ:     if (ack_s)    state_n = NOTICE;
      NOTICE:  if (cnt_done) state_n = SEND;
      SEND:    if (!ack_s)   state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  // next values of the registered outputs; request drops on ack so the slave
  // cannot re-trigger when it returns to waiting for a request
  always_comb begin
    request_n = 1'b0;
    valid_n   = 1'b0;
    notice_n  = 1'b0;
    cnt_n     = '0;
    data_n    = data_out;
    unique case (state)
      IDLE: begin
        if (send) begin
          request_n = 1'b1;
          data_n    = data_sw;
        end
      end
      REQ: begin
        request_n = !ack_s;
        notice_n  = ack_s;
      end
      NOTICE: begin
        notice_n = !cnt_done;
        valid_n  = cnt_done;
        cnt_n    = cnt_done ? '0 : cnt + 1'b1;
      end
      SEND: begin
        valid_n = ack_s;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/master_control.md
# master_control

Master-side control block for the Chip2Chip link. It takes a one-pulse send command and a 3-bit switch value, then runs the request/ack/valid handshake toward the slave board. The block sits between the debounced/one-pulsed push-button and switch inputs on the master FPGA and the inter-board wires `request`, `ack`, `data_out` and `valid`. It also drives a notice LED for a fixed interval once the slave has acknowledged.

## Interface
- `CNT_MAX`, default 100_000_000: notice interval in clock cycles (1 s at 100 MHz); must be ≥ 1.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `send` input 1: one-cycle pulse requesting a transfer; ignored unless in IDLE.
- `data_sw` input 3: value to transmit; sampled only on an accepted `send`.
- `ack` input 1: acknowledge from slave; asynchronous to `clk`.
- `request` output 1: request to slave; registered.
- `valid` output 1: data-valid strobe to slave; registered.
- `data_out` output 3: transmitted value; registered, driven continuously.
- `notice` output 1: LED; high for exactly `CNT_MAX` cycles after ack is seen.
- `busy` output 1: high in every state except IDLE.

## Operation
- `ack` passes through a 2-flop synchronizer (`ack_s`). All FSM decisions use `ack_s`, never raw `ack`.
- Reset (`rst`=1 at an edge): state=IDLE; `request`=0, `valid`=0, `notice`=0, `data_out`=3'b000, `busy`=0; counter=0; both synchronizer flops=0. Reset wins over every other condition, including a reset mid-transfer. After reset the bus is idle and the slave resynchronizes on the next request.
- States and transitions:
  - IDLE: if `send`=1, go to REQ, latch `data_sw` into `data_out`, and set `request`=1. Otherwise stay; `data_out` holds its last value.
  - REQ: hold `request`=1 until `ack_s`=1. Then go to NOTICE with `request`=0, `notice`=1 and counter=0. `request` must drop here so the slave does not re-trigger when it returns to its wait-for-request state.
  - NOTICE: increment the counter each cycle. When counter = `CNT_MAX`-1, go to SEND with `notice`=0, `valid`=1 and counter=0.
  - SEND: hold `valid`=1 and keep `data_out` stable until `ack_s`=0 (the slave has sampled the data and dropped ack). Then go to IDLE with `valid`=0.
- `send` pulses outside IDLE are dropped, not queued. `data_sw` changes outside IDLE do not affect `data_out`.
- The counter is wide enough for `CNT_MAX`-1 (27 bits at the default). The counter never wraps because its terminal value forces the state exit.
- There is no timeout. A slave that never acks leaves the block in REQ until reset.
- `request` and `valid` are never high together. `notice` is never high together with `request` or `valid`.

## Timing
- Accepted `send` at edge T: `request`=1, `busy`=1 and new `data_out` are visible after T.
- Raw `ack` rising before edge A: `ack_s`=1 after A+1. At edge A+2, `request` falls and `notice` rises. Ack-to-response latency is 2–3 cycles.
- `notice` is high for exactly `CNT_MAX` cycles, then `valid` rises on the same edge that `notice` falls.
- Raw `ack` falling before edge B: `valid` falls and `busy` falls at edge B+2.
- Minimum transfer, from `send` to IDLE, with an ideal slave: 1 + (ack delay + 2) + `CNT_MAX` + (ack-drop delay + 2) cycles.

## Test plan
All scenarios use `CNT_MAX`=4.
- Reset: hold `rst`=1 for 3 cycles with `send`=1 and `ack`=1 → `request`=`valid`=`notice`=`busy`=0, `data_out`=0, state stays IDLE.
- Nominal transfer: `data_sw`=3'b101, pulse `send`, raise `ack` 5 cycles later → `request` falls 2 cycles after `ack`; `notice` high exactly 4 cycles; then `valid`=1 with `data_out`=3'b101. Drop `ack` → `valid`=0 2 cycles later and `busy`=0.
- Ignored send: during NOTICE, pulse `send` with `data_sw`=3'b010 → `data_out` stays 3'b101; no second request after returning to IDLE.
- Held data: in SEND, hold `ack` high for 20 cycles while toggling `data_sw` → `valid` stays 1 and `data_out` stays constant throughout.
- Reset mid-operation: assert `rst` in NOTICE, then in SEND → all outputs 0 after the reset edge. A new `send` after reset completes a normal transfer.
- Back-to-back: pulse `send` on the cycle after returning to IDLE with `data_sw`=3'b111 → new `request` next cycle and `data_out`=3'b111.
